cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller that sequences the 16-bit CPU core. It accepts host commands (reset-CPU, run, step N, halt) over a valid/ready port and drives the core's `reset`, `start` and `enable` inputs. It watches the instruction word fed to the core so it can stop on a HALT opcode, and it keeps an enabled-cycle counter and a run watchdog. It sits between the host/debug interface and the CPU core.

## Interface
- `WDOG_CYCLES`, default 65535: max consecutive enabled cycles in one RUN; 0 disables the watchdog.
- `CNT_W`, default 32: width of `cycle_count`.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high controller reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  command: 00 RUN, 01 STEP, 10 HALT, 11 RESET_CPU.
- `cmd_arg`  in  16  step count for STEP; 0 is treated as 1.
- `i_datain`  in  16  instruction word presented to the core; monitored only.
- `cpu_reset_n`  out  1  core reset; the core input is active-low.
- `cpu_start`  out  1  one-cycle start pulse to the core.
- `cpu_enable`  out  1  core clock-enable.
- `busy`  out  1  high in RUN or STEP.
- `halted`  out  1  high in HALTED.
- `cmd_err`  out  1  one-cycle pulse when an accepted command is illegal in the current state.
- `timeout`  out  1  sticky watchdog flag; cleared when the next command is accepted.
- `cycle_count`  out  CNT_W  number of cycles with `cpu_enable`=1.

## Operation
- States: IDLE (core never started), CPURST, START, PAUSED, RUN, STEP, HALTED.
- A command is accepted when `cmd_valid & cmd_ready`.
- `cmd_ready` = 1 in every state except CPURST and START.
- RESET_CPU, accepted in any ready state:
  - CPURST for 2 cycles with `cpu_reset_n`=0.
  - Then START for 1 cycle with `cpu_start`=1.
  - Then PAUSED.
  - `cycle_count` and the step counter are cleared.
- RUN, from PAUSED: go to RUN with `cpu_enable`=1.
- STEP N, from PAUSED: go to STEP. `cpu_enable`=1 for exactly N cycles, then PAUSED.
- HALT, in RUN or STEP: go to PAUSED.
- HALT in PAUSED: accepted, no effect, no error.
- Illegal commands: accepted, no state change, `cmd_err` pulses. These are:
  - RUN or STEP in IDLE or HALTED.
  - RUN or STEP while RUN or STEP is active.
  - HALT in IDLE or HALTED.
- HALT opcode detection: while `cpu_enable`=1 and `i_datain[15:11]` == `OP_HALT`, go to HALTED.
- Priorities within one cycle: HALT opcode > host HALT > last step expiring > watchdog.
- `cycle_count` increments on each cycle with `cpu_enable`=1 and saturates at all-ones.
- Watchdog:
  - Counts consecutive enabled cycles since RUN was accepted.
  - On reaching `WDOG_CYCLES`, go to PAUSED and set `timeout`.
  - STEP is not watchdogged.

## Timing
- Reset values: state IDLE, `cpu_reset_n`=0 (core held in reset), `cpu_start`=0, `cpu_enable`=0, `cmd_ready`=1, `busy`=0, `halted`=0, `cmd_err`=0, `timeout`=0, `cycle_count`=0.
- All outputs are registered.
- For a command accepted in cycle T:
  - RUN: `cpu_enable`=1 from T+1.
  - STEP N: `cpu_enable`=1 in T+1..T+N, 0 at T+N+1.
  - HALT: `cpu_enable`=0 from T+1.
  - RESET_CPU: `cpu_reset_n`=0 in T+1..T+2, `cpu_start`=1 in T+3, PAUSED with `cmd_ready`=1 in T+4.
- HALT opcode seen in cycle H: `cpu_enable`=0 and `halted`=1 from H+1. Cycle H itself is counted.
- HALT opcode in the final step cycle: HALTED, not PAUSED.
- Controller `reset` mid-operation: back to reset values on the next edge. `cpu_reset_n` drops, so the core is also reset.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants, including `OP_HALT` (5 bits).
  - Command encodings `CMD_RUN/STEP/HALT/RESET_CPU`.
  - The state enum.
- Optional sub-module `sat_counter` (parameterised width, enable, clear, saturate). It is used for `cycle_count` and the watchdog.
- The step counter is a 16-bit down-counter inside the FSM.

## Test plan
- Apply `reset` for 2 cycles, then issue RUN -> `cpu_reset_n`=0, `cpu_enable`=0, `cmd_err` pulses, state stays IDLE.
- Issue RESET_CPU at T -> `cpu_reset_n` low T+1..T+2, `cpu_start` high at T+3, `cmd_ready` high at T+4.
- STEP 3 from PAUSED, `i_datain`=ADD words -> `cpu_enable` high exactly 3 cycles, `cycle_count`=3, state PAUSED. Then STEP 0 -> 1 cycle, `cycle_count`=4.
- RUN, then drive `i_datain`={OP_HALT, 11'b0} on the 5th enabled cycle -> `halted`=1 next cycle, `cpu_enable`=0, `cycle_count`=5. A following RUN gives `cmd_err`; RESET_CPU recovers to PAUSED with `cycle_count`=0.
- `WDOG_CYCLES`=8, RUN with no HALT -> `cpu_enable` off after 8 cycles, `timeout`=1, state PAUSED. Next STEP clears `timeout`.
- Host HALT and HALT opcode in the same RUN cycle -> HALTED, not PAUSED. Host HALT alone in RUN -> PAUSED, `cpu_enable`=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core and its run controller.
package cpu_pkg;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned OPCODE_W = 5;
   localparam int unsigned CMD_W    = 2;
   localparam int unsigned STEP_W   = 16;

   // Core opcodes held in instruction bits [15:11]
   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'h00;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'h01;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 5'h02;
   localparam logic [OPCODE_W-1:0] OP_LD   = 5'h08;
   localparam logic [OPCODE_W-1:0] OP_ST   = 5'h09;
   localparam logic [OPCODE_W-1:0] OP_JMP  = 5'h10;
   localparam logic [OPCODE_W-1:0] OP_HALT = 5'h1F;

   // Host command encodings
   localparam logic [CMD_W-1:0] CMD_RUN       = 2'b00;
   localparam logic [CMD_W-1:0] CMD_STEP      = 2'b01;
   localparam logic [CMD_W-1:0] CMD_HALT      = 2'b10;
   localparam logic [CMD_W-1:0] CMD_RESET_CPU = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CPURST,
      ST_START,
      ST_PAUSED,
      ST_RUN,
      ST_STEP,
      ST_HALTED
   } run_state_e;

   // True when the instruction word carries the HALT opcode
   function automatic logic is_halt_op(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: OPCODE_W] == OP_HALT;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   // Clear has priority; increment stops at the maximum value
   always_ff @(posedge clock) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences core reset/start/enable from host commands,
// stops on HALT opcode, counts enabled cycles and watchdogs free runs.
module cpu_run_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned WDOG_CYCLES = 65535,
   parameter int unsigned CNT_W       = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CMD_W-1:0]   cmd_op,
   input  logic [STEP_W-1:0]  cmd_arg,
   input  logic [INSTR_W-1:0] i_datain,
   output logic               cpu_reset_n,
   output logic               cpu_start,
   output logic               cpu_enable,
   output logic               busy,
   output logic               halted,
   output logic               cmd_err,
   output logic               timeout,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam int unsigned       WDOG_W    = 32;
   localparam bit                WDOG_ON   = (WDOG_CYCLES != 0);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   run_state_e        state, state_nxt;
   logic [STEP_W-1:0] step_cnt, step_nxt;
   logic              rst_cnt, rst_nxt;
   logic              err_nxt, tout_nxt, cnt_clr;
   logic              accept, halt_seen, wdog_expire, in_run;
   logic [WDOG_W-1:0] wdog_cnt;

   assign accept      = cmd_valid & cmd_ready;
   assign halt_seen   = is_halt_op(i_datain);
   assign in_run      = (state == ST_RUN);
   assign wdog_expire = WDOG_ON && in_run && (wdog_cnt == WDOG_LAST);

   // Next-state, step counter and flag decisions
   always_comb begin
      state_nxt = state;
      step_nxt  = step_cnt;
      rst_nxt   = rst_cnt;
      err_nxt   = 1'b0;
      tout_nxt  = timeout;
      cnt_clr   = 1'b0;

      if (accept) begin
         tout_nxt = 1'b0;
         unique case (cmd_op)
            CMD_RUN, CMD_STEP: err_nxt = (state != ST_PAUSED);
            CMD_HALT:          err_nxt = (state == ST_IDLE) || (state == ST_HALTED);
            CMD_RESET_CPU:     err_nxt = 1'b0;
         endcase
      end

      case (state)
         ST_CPURST: begin
            rst_nxt = 1'b1;
            if (rst_cnt) state_nxt = ST_START;
         end
         ST_START: state_nxt = ST_PAUSED;
         ST_PAUSED: begin
            if (accept && (cmd_op == CMD_RUN)) begin
               state_nxt = ST_RUN;
            end else if (accept && (cmd_op == CMD_STEP)) begin
               state_nxt = ST_STEP;
               step_nxt  = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
            end
         end
         ST_RUN, ST_STEP: begin
            if (state == ST_STEP) step_nxt = step_cnt - STEP_W'(1);
            if (halt_seen) begin
               state_nxt = ST_HALTED;
            end else if (accept && (cmd_op == CMD_HALT)) begin
               state_nxt = ST_PAUSED;
            end else if ((state == ST_STEP) && (step_cnt == STEP_W'(1))) begin
               state_nxt = ST_PAUSED;
            end else if (wdog_expire) begin
               state_nxt = ST_PAUSED;
               tout_nxt  = 1'b1;
            end
         end
         default: ;
      endcase

      // Core reset request overrides whatever else happened this cycle
      if (accept && (cmd_op == CMD_RESET_CPU)) begin
         state_nxt = ST_CPURST;
         rst_nxt   = 1'b0;
         step_nxt  = '0;
         cnt_clr   = 1'b1;
      end
   end

   // State register; outputs registered from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         step_cnt    <= '0;
         rst_cnt     <= 1'b0;
         cmd_ready   <= 1'b1;
         cpu_reset_n <= 1'b0;
         cpu_start   <= 1'b0;
         cpu_enable  <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         cmd_err     <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         step_cnt    <= step_nxt;
         rst_cnt     <= rst_nxt;
         cmd_ready   <= (state_nxt != ST_CPURST) && (state_nxt != ST_START);
         cpu_reset_n <= (state_nxt != ST_IDLE) && (state_nxt != ST_CPURST);
         cpu_start   <= (state_nxt == ST_START);
         cpu_enable  <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
         busy        <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
         halted      <= (state_nxt == ST_HALTED);
         cmd_err     <= err_nxt;
         timeout     <= tout_nxt;
      end
   end

   // Enabled-cycle counter
   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cpu_enable),
      .count (cycle_count)
   );

   // Consecutive RUN cycles; held at zero outside RUN
   sat_counter #(.W(WDOG_W)) u_wdog_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (!in_run),
      .en    (in_run),
      .count (wdog_cnt)
   );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios then random commands,
// every cycle compared against a behavioural model.
module tb_cpu_run_ctrl;
   import cpu_pkg::*;

   localparam int unsigned WDOG  = 8;
   localparam int unsigned CW    = 5;
   localparam int unsigned CMAX  = (1 << CW) - 1;

   localparam int M_IDLE = 0, M_CPURST = 1, M_START = 2, M_PAUSED = 3,
                  M_RUN = 4, M_STEP = 5, M_HALTED = 6;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [15:0]   cmd_arg = 16'h0;
   logic [15:0]   i_datain = 16'h0;
   logic          cpu_reset_n, cpu_start, cpu_enable, busy, halted, cmd_err, timeout;
   logic [CW-1:0] cycle_count;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model state
   int          m_mode;
   int          m_rst_left;
   int          m_steps;
   int          m_run;
   int unsigned m_count;
   bit          m_err;
   bit          m_tout;

   logic [15:0] w_add, w_halt;

   cpu_run_ctrl #(.WDOG_CYCLES(WDOG), .CNT_W(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_arg     (cmd_arg),
      .i_datain    (i_datain),
      .cpu_reset_n (cpu_reset_n),
      .cpu_start   (cpu_start),
      .cpu_enable  (cpu_enable),
      .busy        (busy),
      .halted      (halted),
      .cmd_err     (cmd_err),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      bit active;
      active = (m_mode == M_RUN) || (m_mode == M_STEP);
      chk("cmd_ready",   32'(cmd_ready),   32'(!(m_mode == M_CPURST || m_mode == M_START)));
      chk("cpu_reset_n", 32'(cpu_reset_n), 32'(!(m_mode == M_IDLE || m_mode == M_CPURST)));
      chk("cpu_start",   32'(cpu_start),   32'(m_mode == M_START));
      chk("cpu_enable",  32'(cpu_enable),  32'(active));
      chk("busy",        32'(busy),        32'(active));
      chk("halted",      32'(halted),      32'(m_mode == M_HALTED));
      chk("cmd_err",     32'(cmd_err),     32'(m_err));
      chk("timeout",     32'(timeout),     32'(m_tout));
      chk("cycle_count", 32'(cycle_count), m_count);
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_rst_left = 0; m_steps = 0; m_run = 0;
      m_count = 0; m_err = 0; m_tout = 0;
   endtask

   // One clock of the specified behaviour, given this cycle's inputs
   task automatic model_step(input bit v, input logic [1:0] op,
                             input logic [15:0] arg, input logic [15:0] data);
      bit ready, acc, en;
      int nm;
      ready = !(m_mode == M_CPURST || m_mode == M_START);
      acc   = v && ready;
      en    = (m_mode == M_RUN) || (m_mode == M_STEP);
      nm    = m_mode;
      m_err = 0;
      if (acc) m_tout = 0;
      if (en && m_count < CMAX) m_count++;
      if (acc && op == CMD_RESET_CPU) begin
         nm = M_CPURST; m_rst_left = 2; m_count = 0;
      end else begin
         if (acc) begin
            if (op == CMD_HALT) m_err = (m_mode == M_IDLE) || (m_mode == M_HALTED);
            else                m_err = (m_mode != M_PAUSED);
         end
         case (m_mode)
            M_CPURST: begin
               m_rst_left--;
               if (m_rst_left == 0) nm = M_START;
            end
            M_START: nm = M_PAUSED;
            M_PAUSED: begin
               if (acc && op == CMD_RUN) begin
                  nm = M_RUN; m_run = 0;
               end else if (acc && op == CMD_STEP) begin
                  nm = M_STEP; m_steps = (arg == 0) ? 1 : int'(arg);
               end
            end
            M_RUN, M_STEP: begin
               if (m_mode == M_STEP) m_steps--; else m_run++;
               if (data[15:11] == OP_HALT)                          nm = M_HALTED;
               else if (acc && op == CMD_HALT)                      nm = M_PAUSED;
               else if (m_mode == M_STEP && m_steps == 0)           nm = M_PAUSED;
               else if (m_mode == M_RUN && m_run == int'(WDOG)) begin
                  nm = M_PAUSED; m_tout = 1;
               end
            end
            default: ;
         endcase
      end
      m_mode = nm;
   endtask

   task automatic tick(input bit v, input logic [1:0] op,
                       input logic [15:0] arg, input logic [15:0] data);
      cmd_valid = v; cmd_op = op; cmd_arg = arg; i_datain = data;
      model_step(v, op, arg, data);
      @(posedge clock);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, CMD_RUN, 16'h0, w_add);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; cmd_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         cyc++;
         model_reset();
         check_all();
      end
      reset = 1'b0;
   endtask

   task automatic cpu_restart();
      tick(1'b1, CMD_RESET_CPU, 16'h0, w_add);
      idle(3);
   endtask

   initial begin
      w_add  = {OP_ADD, 11'h123};
      w_halt = {OP_HALT, 11'h000};
      model_reset();

      // Controller reset and RUN before the core was ever started
      do_reset(2);
      chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
      chk("rst_cmd_ready",   32'(cmd_ready),   32'd1);
      tick(1'b1, CMD_RUN, 16'h0, w_add);
      chk("idle_run_err",    32'(cmd_err),     32'd1);
      chk("idle_run_enable", 32'(cpu_enable),  32'd0);
      idle(1);

      // RESET_CPU sequencing
      tick(1'b1, CMD_RESET_CPU, 16'h0, w_add);
      chk("rcpu_t1_rstn", 32'(cpu_reset_n), 32'd0);
      idle(1);
      chk("rcpu_t2_rstn", 32'(cpu_reset_n), 32'd0);
      idle(1);
      chk("rcpu_t3_start", 32'(cpu_start), 32'd1);
      idle(1);
      chk("rcpu_t4_ready", 32'(cmd_ready), 32'd1);

      // STEP 3 then STEP 0
      tick(1'b1, CMD_STEP, 16'd3, w_add);
      idle(3);
      chk("step3_enable", 32'(cpu_enable), 32'd0);
      chk("step3_count",  32'(cycle_count), 32'd3);
      tick(1'b1, CMD_STEP, 16'd0, w_add);
      idle(1);
      chk("step0_count",  32'(cycle_count), 32'd4);

      // RUN stopped by HALT opcode on the 5th enabled cycle
      cpu_restart();
      tick(1'b1, CMD_RUN, 16'h0, w_add);
      idle(4);
      tick(1'b0, CMD_RUN, 16'h0, w_halt);
      chk("hop_halted", 32'(halted),      32'd1);
      chk("hop_enable", 32'(cpu_enable),  32'd0);
      chk("hop_count",  32'(cycle_count), 32'd5);
      tick(1'b1, CMD_RUN, 16'h0, w_add);
      chk("halted_run_err", 32'(cmd_err), 32'd1);
      cpu_restart();
      chk("recover_count", 32'(cycle_count), 32'd0);
      chk("recover_ready", 32'(cmd_ready),   32'd1);

      // Watchdog expiry, then STEP clears the flag
      tick(1'b1, CMD_RUN, 16'h0, w_add);
      idle(8);
      chk("wdog_enable",  32'(cpu_enable),  32'd0);
      chk("wdog_timeout", 32'(timeout),     32'd1);
      chk("wdog_count",   32'(cycle_count), 32'd8);
      tick(1'b1, CMD_STEP, 16'd1, w_add);
      chk("wdog_clear",   32'(timeout),     32'd0);
      idle(1);

      // Host HALT together with HALT opcode
      tick(1'b1, CMD_RUN, 16'h0, w_add);
      idle(2);
      tick(1'b1, CMD_HALT, 16'h0, w_halt);
      chk("both_halted", 32'(halted), 32'd1);
      cpu_restart();

      // Host HALT alone
      tick(1'b1, CMD_RUN, 16'h0, w_add);
      idle(2);
      tick(1'b1, CMD_HALT, 16'h0, w_add);
      chk("hhalt_enable", 32'(cpu_enable), 32'd0);
      chk("hhalt_halted", 32'(halted),     32'd0);
      tick(1'b1, CMD_HALT, 16'h0, w_add);
      chk("paused_halt_noerr", 32'(cmd_err), 32'd0);

      // HALT opcode on the final step cycle
      tick(1'b1, CMD_STEP, 16'd2, w_add);
      idle(1);
      tick(1'b0, CMD_RUN, 16'h0, w_halt);
      chk("laststep_halted", 32'(halted), 32'd1);

      // Controller reset mid-run
      cpu_restart();
      tick(1'b1, CMD_RUN, 16'h0, w_add);
      idle(3);
      do_reset(1);
      chk("midrst_rstn",   32'(cpu_reset_n), 32'd0);
      chk("midrst_enable", 32'(cpu_enable),  32'd0);

      // Random command traffic
      cpu_restart();
      for (int i = 0; i < 800; i++) begin
         bit          v;
         logic [1:0]  op;
         logic [15:0] arg, data;
         int          r;
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1);
            continue;
         end
         v   = ($urandom_range(0, 3) == 0);
         r   = $urandom_range(0, 99);
         op  = (r < 40) ? CMD_RUN : (r < 70) ? CMD_STEP : (r < 94) ? CMD_HALT : CMD_RESET_CPU;
         arg = 16'($urandom_range(0, 6));
         data = ($urandom_range(0, 39) == 0) ? w_halt : {5'($urandom_range(0, 30)), 11'($urandom)};
         tick(v, op, arg, data);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
